stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have one parameter: P_HOUR_WRAP, default 24, hour value at which the hour field wraps to 0.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low. Ports, clock and reset first:
- i_clk  input  1  system clock, 100 MHz.
- i_rstn  input  1  asynchronous active-low reset.
- i_start_stop  input  1  single-cycle pulse; start or pause timing.
- i_clear  input  1  single-cycle pulse; zero the time and return to idle.
- i_lap  input  1  single-cycle pulse; toggle display freeze while running.
- i_ms_pulse  input  1  one-cycle tick from the millisecond counter.
- o_cnt_enable  output  1  enable and synchronous clear for the millisecond counter.
- o_running  output  1  high while in RUN.
- o_frozen  output  1  high while the display is frozen.
- o_ms  output  10  displayed milliseconds, 0-999.
- o_sec  output  6  displayed seconds, 0-59.
- o_min  output  6  displayed minutes, 0-59.
- o_hour  output  5  displayed hours, 0 to P_HOUR_WRAP-1.
- o_state  output  2  IDLE=00, RUN=01, PAUSE=10.

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN and PAUSE; the code 11 SHALL be unreachable and SHALL recover to IDLE on the next edge.
REQ-004 The FSM SHALL make these transitions:
- IDLE to RUN on i_start_stop.
- RUN to PAUSE on i_start_stop.
- PAUSE to RUN on i_start_stop.
- Any state to IDLE on i_clear.
REQ-005 i_clear SHALL take priority over i_start_stop and i_lap in the same cycle.
REQ-006 o_cnt_enable SHALL be a registered output, high exactly when the registered state is RUN; it SHALL rise one cycle after the start edge and fall one cycle after the stop edge.
REQ-007 Dropping o_cnt_enable discards the partial millisecond; the block SHALL NOT compensate for it.
REQ-008 The internal time registers SHALL advance by one millisecond on each edge where state is RUN and i_ms_pulse=1, including the edge on which i_start_stop moves RUN to PAUSE.
REQ-009 i_ms_pulse SHALL be ignored in IDLE and PAUSE, and on any edge where i_clear=1.
REQ-010 The time fields SHALL carry as a BCD-free cascade:
- ms 999 wraps to 0 and increments sec.
- sec 59 wraps to 0 and increments min.
- min 59 wraps to 0 and increments hour.
- hour P_HOUR_WRAP-1 wraps to 0 with no overflow flag.
- All carries resolve within the same edge.
REQ-011 On i_clear, all four internal fields SHALL become 0 on that edge.
REQ-012 i_lap in RUN SHALL toggle o_frozen.
REQ-013 When o_frozen rises, the display registers SHALL capture the internal time as it is after that edge's increment.
REQ-014 While o_frozen=1, the display SHALL hold its value while the internal time continues to advance.
REQ-015 When o_frozen falls, the display SHALL track the internal time again from the next edge.
REQ-016 i_lap in IDLE or PAUSE SHALL be ignored.
REQ-017 i_clear SHALL reset o_frozen to 0.
REQ-018 PAUSE SHALL preserve o_frozen.
REQ-019 When not frozen, o_ms, o_sec, o_min and o_hour SHALL equal the internal time registers, with one cycle of latency from the increment edge.
REQ-020 o_running SHALL equal (o_state==RUN) and SHALL be registered.
REQ-021 Input pulses wider than one cycle SHALL be treated as one event per cycle high; edge detection is the caller's responsibility.

Reset
REQ-022 While i_rstn=0, every output and every internal register SHALL be 0, and o_state SHALL be IDLE, regardless of the clock.
REQ-023 Reset asserted mid-RUN SHALL drop o_cnt_enable immediately (asynchronously) and discard the frozen snapshot.
REQ-024 After i_rstn deasserts, the block SHALL ignore inputs only on the first edge of synchronous release; from the second edge it SHALL obey REQ-004 onward.

Verification
REQ-025 Start and tick: start pulse, then 1500 ms pulses -> o_cnt_enable=1 one cycle after start; display reaches ms=500, sec=1.
REQ-026 Cascade wrap: preload by ticking to 00:59:59.999, then one tick -> 01:00:00.000 in one edge; with P_HOUR_WRAP=24, 23:59:59.999 plus one tick -> 00:00:00.000.
REQ-027 Pause and resume: a stop pulse coincident with i_ms_pulse -> that tick is counted; ticks in PAUSE -> no change; start again -> counting resumes from the held value.
REQ-028 Lap freeze: lap at ms=250, then 100 ticks -> display holds 250 while internal time is 350; second lap -> display 350 next cycle.
REQ-029 Priority: i_clear, i_start_stop and i_lap all high in RUN -> state IDLE, all fields 0, o_frozen=0, o_cnt_enable=0 next cycle.
REQ-030 Async reset: assert i_rstn=0 mid-RUN between clock edges -> all outputs 0 immediately; on release, state stays IDLE until a start pulse.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE sequencing, ms/sec/min/hour time cascade,
// and a lap-freeze display snapshot.
//
// state | meaning
// IDLE  | time zeroed, counter disabled, waiting for start
// RUN   | millisecond counter enabled, time advances on i_ms_pulse
// PAUSE | time held, display still reflects held value
module stopwatch_ctrl #(
  parameter int P_HOUR_WRAP = 24
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_start_stop,
  input  logic       i_clear,
  input  logic       i_lap,
  input  logic       i_ms_pulse,
  output logic       o_cnt_enable,
  output logic       o_running,
  output logic       o_frozen,
  output logic [9:0] o_ms,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  localparam logic [9:0] MS_MAX   = 10'd999;
  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'(P_HOUR_WRAP - 1);

  state_t     state_q, state_d;
  logic       armed_q;
  logic       cnt_en_q, running_q;
  logic       frozen_q, frozen_d;
  logic [9:0] ms_q, ms_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic [9:0] disp_ms_q, disp_ms_d;
  logic [5:0] disp_sec_q, disp_sec_d;
  logic [5:0] disp_min_q, disp_min_d;
  logic [4:0] disp_hour_q, disp_hour_d;

  logic start_ev, clear_ev, lap_ev, tick_ev;
  logic in_run;

  // The first edge after reset release only arms the block; all inputs are gated until then.
  assign start_ev = i_start_stop & armed_q;
  assign clear_ev = i_clear      & armed_q;
  assign lap_ev   = i_lap        & armed_q;
  assign tick_ev  = i_ms_pulse   & armed_q;
  assign in_run   = (state_q == S_RUN);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      cnt_en_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_en_q  <= (state_d == S_RUN);
      running_q <= (state_d == S_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ev) state_d = S_RUN;
      S_RUN:   if (start_ev) state_d = S_PAUSE;
      S_PAUSE: if (start_ev) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (clear_ev) begin
      state_d = S_IDLE;
    end
  end

  // Full carry cascade resolves in one edge.
  always_comb begin
    ms_d   = ms_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (clear_ev) begin
      ms_d   = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (in_run && tick_ev) begin
      if (ms_q != MS_MAX) begin
        ms_d = ms_q + 10'd1;
      end else begin
        ms_d = '0;
        if (sec_q != SEC_MAX) begin
          sec_d = sec_q + 6'd1;
        end else begin
          sec_d = '0;
          if (min_q != MIN_MAX) begin
            min_d = min_q + 6'd1;
          end else begin
            min_d = '0;
            if (hour_q != HOUR_MAX) begin
              hour_d = hour_q + 5'd1;
            end else begin
              hour_d = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ms_q   <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else begin
      ms_q   <= ms_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  end

  // Freeze captures post-increment time; unfreeze holds one edge, then tracks with one-cycle lag.
  always_comb begin
    frozen_d    = frozen_q;
    disp_ms_d   = disp_ms_q;
    disp_sec_d  = disp_sec_q;
    disp_min_d  = disp_min_q;
    disp_hour_d = disp_hour_q;
    if (clear_ev) begin
      frozen_d    = 1'b0;
      disp_ms_d   = '0;
      disp_sec_d  = '0;
      disp_min_d  = '0;
      disp_hour_d = '0;
    end else if (in_run && lap_ev) begin
      frozen_d = ~frozen_q;
      if (!frozen_q) begin
        disp_ms_d   = ms_d;
        disp_sec_d  = sec_d;
        disp_min_d  = min_d;
        disp_hour_d = hour_d;
      end
    end else if (!frozen_q) begin
      disp_ms_d   = ms_q;
      disp_sec_d  = sec_q;
      disp_min_d  = min_q;
      disp_hour_d = hour_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      frozen_q    <= 1'b0;
      disp_ms_q   <= '0;
      disp_sec_q  <= '0;
      disp_min_q  <= '0;
      disp_hour_q <= '0;
    end else begin
      frozen_q    <= frozen_d;
      disp_ms_q   <= disp_ms_d;
      disp_sec_q  <= disp_sec_d;
      disp_min_q  <= disp_min_d;
      disp_hour_q <= disp_hour_d;
    end
  end

  assign o_cnt_enable = cnt_en_q;
  assign o_running    = running_q;
  assign o_frozen     = frozen_q;
  assign o_ms         = disp_ms_q;
  assign o_sec        = disp_sec_q;
  assign o_min        = disp_min_q;
  assign o_hour       = disp_hour_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random traffic
// against an elapsed-milliseconds reference model.
module tb_stopwatch_ctrl;

  localparam int HW   = 24;
  localparam int WRAP = HW * 3600000;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_start_stop = 1'b0;
  logic       i_clear = 1'b0;
  logic       i_lap = 1'b0;
  logic       i_ms_pulse = 1'b0;
  logic       o_cnt_enable, o_running, o_frozen;
  logic [9:0] o_ms;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic [1:0] o_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state 0=IDLE 1=RUN 2=PAUSE, time as total elapsed ms.
  int m_state  = 0;
  int m_total  = 0;
  int m_disp   = 0;
  bit m_frozen = 0;
  bit m_armed  = 0;

  stopwatch_ctrl #(.P_HOUR_WRAP(HW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start_stop(i_start_stop), .i_clear(i_clear),
    .i_lap(i_lap), .i_ms_pulse(i_ms_pulse), .o_cnt_enable(o_cnt_enable),
    .o_running(o_running), .o_frozen(o_frozen), .o_ms(o_ms), .o_sec(o_sec),
    .o_min(o_min), .o_hour(o_hour), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [26:0] pack_time(input int t);
    int ms, s, m, h;
    ms = t % 1000;
    s  = (t / 1000) % 60;
    m  = (t / 60000) % 60;
    h  = t / 3600000;
    return {5'(h), 6'(m), 6'(s), 10'(ms)};
  endfunction

  function automatic logic [4:0] exp_status();
    return {2'(m_state), m_state == 1, m_state == 1, m_frozen};
  endfunction

  function automatic void model_reset();
    m_state = 0; m_total = 0; m_disp = 0; m_frozen = 0; m_armed = 0;
  endfunction

  function automatic void model_edge(input bit ss, input bit clr, input bit lap, input bit tick);
    int prev;
    if (!m_armed) begin
      m_armed = 1;
    end else if (clr) begin
      m_state = 0; m_total = 0; m_disp = 0; m_frozen = 0;
    end else begin
      prev = m_total;
      if (m_state == 1 && tick) m_total = (m_total + 1) % WRAP;
      if (m_state == 1 && lap) begin
        if (!m_frozen) begin
          m_frozen = 1;
          m_disp   = m_total;
        end else begin
          m_frozen = 0;
        end
      end else if (!m_frozen) begin
        m_disp = prev;
      end
      if (ss) m_state = (m_state == 1) ? 2 : 1;
    end
  endfunction

  task automatic cycle(input bit ss, input bit clr, input bit lap, input bit tick);
    i_start_stop = ss; i_clear = clr; i_lap = lap; i_ms_pulse = tick;
    @(posedge i_clk);
    model_edge(ss, clr, lap, tick);
    #1;
    i_start_stop = 0; i_clear = 0; i_lap = 0; i_ms_pulse = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1);
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({o_state, o_running, o_cnt_enable, o_frozen} !== 5'b0) begin
      n_fail++; $display("FAIL reset_status: got %b expected 00000", {o_state, o_running, o_cnt_enable, o_frozen});
    end
    n_checks++;
    if ({o_hour, o_min, o_sec, o_ms} !== 27'b0) begin
      n_fail++; $display("FAIL reset_time: got %h expected 0", {o_hour, o_min, o_sec, o_ms});
    end
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
    model_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_start_tick();
    cycle(1, 0, 0, 0);
    n_checks++;
    if (o_cnt_enable !== 1'b1 || o_state !== 2'b01) begin
      n_fail++; $display("FAIL start_enable: got en=%b st=%b expected en=1 st=01", o_cnt_enable, o_state);
    end
    for (int i = 0; i < 1500; i++) begin
      while ($urandom_range(0, 3) == 0) cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 1);
    end
    cycle(0, 0, 0, 0);
    n_checks++;
    if ({o_hour, o_min, o_sec, o_ms} !== pack_time(1500) || pack_time(m_disp) !== pack_time(1500)) begin
      n_fail++; $display("FAIL start_1500ms: got %0d:%0d.%0d expected 0:1.500", o_min, o_sec, o_ms);
    end
  endtask

  task automatic test_pause_resume();
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    ticks(10);
    cycle(1, 0, 0, 1);
    n_checks++;
    if ({o_state, o_running, o_cnt_enable, o_frozen} !== 5'b10000) begin
      n_fail++; $display("FAIL pause_status: got %b expected 10000", {o_state, o_running, o_cnt_enable, o_frozen});
    end
    ticks(20);
    cycle(0, 0, 0, 0);
    n_checks++;
    if ({o_hour, o_min, o_sec, o_ms} !== pack_time(11)) begin
      n_fail++; $display("FAIL pause_hold: got ms=%0d expected 11", o_ms);
    end
    cycle(1, 0, 0, 0);
    ticks(5);
    cycle(0, 0, 0, 0);
    n_checks++;
    if ({o_hour, o_min, o_sec, o_ms} !== pack_time(16) || o_state !== 2'b01) begin
      n_fail++; $display("FAIL resume: got ms=%0d st=%b expected ms=16 st=01", o_ms, o_state);
    end
  endtask

  task automatic test_lap();
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    ticks(250);
    cycle(0, 0, 1, 0);
    n_checks++;
    if (o_frozen !== 1'b1 || {o_hour, o_min, o_sec, o_ms} !== pack_time(250)) begin
      n_fail++; $display("FAIL lap_capture: got frz=%b ms=%0d expected frz=1 ms=250", o_frozen, o_ms);
    end
    ticks(100);
    n_checks++;
    if (o_frozen !== 1'b1 || {o_hour, o_min, o_sec, o_ms} !== pack_time(250) || m_total != 350) begin
      n_fail++; $display("FAIL lap_hold: got frz=%b ms=%0d expected frz=1 ms=250", o_frozen, o_ms);
    end
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    n_checks++;
    if (o_frozen !== 1'b0 || {o_hour, o_min, o_sec, o_ms} !== pack_time(350)) begin
      n_fail++; $display("FAIL lap_release: got frz=%b ms=%0d expected frz=0 ms=350", o_frozen, o_ms);
    end
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    n_checks++;
    if (o_frozen !== 1'b0 || o_state !== 2'b10) begin
      n_fail++; $display("FAIL lap_in_pause: got frz=%b st=%b expected frz=0 st=10", o_frozen, o_state);
    end
  endtask

  task automatic preload(input int t);
    force dut.ms_q   = 10'(t % 1000);
    force dut.sec_q  = 6'((t / 1000) % 60);
    force dut.min_q  = 6'((t / 60000) % 60);
    force dut.hour_q = 5'(t / 3600000);
    #1;
    release dut.ms_q;
    release dut.sec_q;
    release dut.min_q;
    release dut.hour_q;
    m_total = t;
  endtask

  task automatic test_cascade();
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    preload(3599999);
    cycle(0, 0, 0, 0);
    n_checks++;
    if ({o_hour, o_min, o_sec, o_ms} !== {5'd0, 6'd59, 6'd59, 10'd999}) begin
      n_fail++; $display("FAIL preload_hour: got %0d:%0d:%0d.%0d expected 0:59:59.999", o_hour, o_min, o_sec, o_ms);
    end
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    n_checks++;
    if ({o_hour, o_min, o_sec, o_ms} !== {5'd1, 6'd0, 6'd0, 10'd0}) begin
      n_fail++; $display("FAIL hour_carry: got %0d:%0d:%0d.%0d expected 1:0:0.0", o_hour, o_min, o_sec, o_ms);
    end
    preload(WRAP - 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    n_checks++;
    if ({o_hour, o_min, o_sec, o_ms} !== 27'd0 || pack_time(m_disp) !== 27'd0) begin
      n_fail++; $display("FAIL day_wrap: got %0d:%0d:%0d.%0d expected 0:0:0.0", o_hour, o_min, o_sec, o_ms);
    end
  endtask

  task automatic test_priority();
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    ticks(37);
    cycle(0, 0, 1, 1);
    cycle(1, 1, 1, 1);
    n_checks++;
    if ({o_state, o_running, o_cnt_enable, o_frozen} !== 5'b0 || {o_hour, o_min, o_sec, o_ms} !== 27'd0) begin
      n_fail++; $display("FAIL priority_clear: got st=%b en=%b frz=%b ms=%0d expected all 0", o_state, o_cnt_enable, o_frozen, o_ms);
    end
  endtask

  task automatic test_async_reset();
    cycle(1, 0, 0, 0);
    ticks(40);
    cycle(0, 0, 1, 1);
    #2;
    i_rstn = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({o_state, o_running, o_cnt_enable, o_frozen} !== 5'b0 || {o_hour, o_min, o_sec, o_ms} !== 27'd0) begin
      n_fail++; $display("FAIL async_reset: got st=%b en=%b frz=%b ms=%0d expected all 0", o_state, o_cnt_enable, o_frozen, o_ms);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
    cycle(1, 0, 0, 0);
    n_checks++;
    if (o_state !== 2'b00 || o_cnt_enable !== 1'b0) begin
      n_fail++; $display("FAIL release_first_edge: got st=%b en=%b expected st=00 en=0", o_state, o_cnt_enable);
    end
    ticks(5);
    n_checks++;
    if (o_state !== 2'b00 || {o_hour, o_min, o_sec, o_ms} !== 27'd0) begin
      n_fail++; $display("FAIL release_idle: got st=%b ms=%0d expected st=00 ms=0", o_state, o_ms);
    end
    cycle(1, 0, 0, 0);
    n_checks++;
    if (o_state !== 2'b01 || o_cnt_enable !== 1'b1) begin
      n_fail++; $display("FAIL release_start: got st=%b en=%b expected st=01 en=1", o_state, o_cnt_enable);
    end
  endtask

  task automatic test_random();
    bit ss, clr, lap, tick;
    for (int i = 0; i < 4000; i++) begin
      ss   = ($urandom_range(0, 39) == 0);
      clr  = ($urandom_range(0, 399) == 0);
      lap  = ($urandom_range(0, 59) == 0);
      tick = ($urandom_range(0, 3) != 0);
      cycle(ss, clr, lap, tick);
      n_checks++;
      if ({o_state, o_running, o_cnt_enable, o_frozen} !== exp_status()) begin
        n_fail++; $display("FAIL rand_status[%0d]: got %b expected %b", i, {o_state, o_running, o_cnt_enable, o_frozen}, exp_status());
      end
      n_checks++;
      if ({o_hour, o_min, o_sec, o_ms} !== pack_time(m_disp)) begin
        n_fail++; $display("FAIL rand_time[%0d]: got %h expected %h", i, {o_hour, o_min, o_sec, o_ms}, pack_time(m_disp));
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_tick();
    test_pause_resume();
    test_lap();
    test_cascade();
    test_priority();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
